// File: rtl/ysyx_22050550_ifu_pkg.sv
// Shared constants for the instruction fetch unit: state encoding, reset PC,
// fault instruction value and AXI read response codes.
package ysyx_22050550_ifu_pkg;

  localparam int REG_BUS   = 64;
  localparam int INST_BITS = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [REG_BUS-1:0]   RESET_PC   = 64'h0000_0000_8000_0000;
  localparam logic [INST_BITS-1:0] FAULT_INST = 32'h0000_0000;
  localparam logic [1:0]           RRESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_22050550_ifu.sv
// Instruction fetch unit: fetches one 32-bit instruction per PC over a
// read-only AXI-lite port and holds it in an IF/ID buffer until decode takes it.
//
// state | meaning
// IDLE  | latch next PC, check alignment
// REQ   | read address phase in flight
// WAIT  | waiting for read data (dropped if a redirect was seen)
// HOLD  | IF/ID buffer valid, waiting for decode handshake
module ysyx_22050550_ifu
  import ysyx_22050550_ifu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] pc_i,
  input  logic        redirect_i,
  output logic        pc_advance_o,
  output logic        imem_arvalid_o,
  input  logic        imem_arready_i,
  output logic [63:0] imem_araddr_o,
  input  logic        imem_rvalid_i,
  output logic        imem_rready_o,
  input  logic [63:0] imem_rdata_i,
  input  logic [1:0]  imem_rresp_i,
  output logic        if_valid_o,
  input  logic        id_ready_i,
  output logic [63:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_fault_o
);

  logic [1:0]  state_q;
  logic [63:0] pc_q;
  logic        drop_q;
  logic [63:0] buf_pc_q;
  logic [31:0] buf_inst_q;
  logic        buf_fault_q;

  logic        rresp_err;
  logic [31:0] rdata_sel;

  assign rresp_err = (imem_rresp_i != RRESP_OKAY);
  assign rdata_sel = pc_q[2] ? imem_rdata_i[63:32] : imem_rdata_i[31:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      buf_pc_q    <= '0;
      buf_inst_q  <= '0;
      buf_fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pc_q   <= pc_i;
          drop_q <= 1'b0;
          if (pc_i[1:0] != 2'b00) begin
            // misaligned PC never reaches the bus
            state_q     <= S_HOLD;
            buf_pc_q    <= pc_i;
            buf_inst_q  <= FAULT_INST;
            buf_fault_q <= 1'b1;
          end else begin
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (redirect_i) drop_q <= 1'b1;
          if (imem_arready_i) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            if (drop_q || redirect_i) begin
              state_q <= S_IDLE;
            end else begin
              state_q     <= S_HOLD;
              buf_pc_q    <= pc_q;
              buf_fault_q <= rresp_err;
              buf_inst_q  <= rresp_err ? FAULT_INST : rdata_sel;
            end
          end else if (redirect_i) begin
            drop_q <= 1'b1;
          end
        end
        S_HOLD: begin
          // redirect wins over a simultaneous id_ready
          if (redirect_i || id_ready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_arvalid_o = (state_q == S_REQ);
  assign imem_araddr_o  = {pc_q[63:3], 3'b000};
  assign imem_rready_o  = (state_q == S_WAIT);
  assign if_valid_o     = (state_q == S_HOLD);
  assign pc_advance_o   = (state_q == S_HOLD) && id_ready_i && !redirect_i;
  assign if_pc_o        = buf_pc_q;
  assign if_inst_o      = buf_inst_q;
  assign if_fault_o     = buf_fault_q;

endmodule

// File: doc/ysyx_22050550_ifu.md
# ysyx_22050550_ifu

Instruction fetch unit sitting directly downstream of the PC register. It takes the combinational next-PC, fetches the 32-bit instruction over a read-only AXI-lite-style instruction-memory port, and holds the result in an IF/ID output buffer under valid/ready handshake. It returns a one-cycle advance pulse that drives the PC register's `ready`, and discards wrong-path fetches when decode signals a taken redirect.

## Interface
- No parameters. Widths come from the shared define file: `RegBus` is 64 bits, instruction is 32 bits.
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `pc_i`  in  64  next PC from the PC register's `npc`.
- `redirect_i`  in  1  taken redirect from decode, equal to `Id_jal != 0 && Id_valid`.
- `pc_advance_o`  out  1  to the PC register's `ready`; the PC register latches `Pc_4` on the same edge.
- `imem_arvalid_o` / `imem_arready_i`  out/in  1  read-address handshake.
- `imem_araddr_o`  out  64  8-byte-aligned fetch address.
- `imem_rvalid_i` / `imem_rready_o`  in/out  1  read-data handshake.
- `imem_rdata_i`  in  64  read data.
- `imem_rresp_i`  in  2  read response; non-zero means error.
- `if_valid_o` / `id_ready_i`  out/in  1  IF/ID handshake.
- `if_pc_o`  out  64  PC of the held instruction.
- `if_inst_o`  out  32  held instruction.
- `if_fault_o`  out  1  access or misalignment fault for the held instruction.

## Operation
- States are IDLE, REQ, WAIT and HOLD. Reset enters IDLE.
- **IDLE** (one cycle):
  - Latch `pc_q <= pc_i` and clear `drop_q`.
  - If `pc_i[1:0] != 0`, go to HOLD with fault. Otherwise go to REQ.
- **REQ**:
  - `imem_arvalid_o=1` and `imem_araddr_o={pc_q[63:3],3'b0}`. Both are stable until `imem_arready_i`.
  - Go to WAIT on `imem_arready_i`.
- **WAIT**:
  - `imem_rready_o=1`.
  - On `imem_rvalid_i`:
    - If `drop_q`, go to IDLE and discard the data.
    - Otherwise capture the instruction, selecting `pc_q[2] ? rdata[63:32] : rdata[31:0]`.
    - Set `fault = (rresp != 0)`. On a fault the instruction field is forced to `32'h0`.
    - Go to HOLD.
- **HOLD**:
  - `if_valid_o=1`; outputs are stable until the handshake.
  - A handshake is `if_valid_o && id_ready_i && !redirect_i`. On a handshake, `pc_advance_o=1` and the next state is IDLE.
- **Redirect**:
  - In REQ or WAIT: set `drop_q`. The bus transaction always completes and is never abandoned.
  - In HOLD: drop the buffer and go to IDLE; no advance.
  - In IDLE: no action needed. `pc_i` already shows the jump target, which is latched.
- `pc_advance_o` is asserted only in the HOLD handshake cycle. It is never asserted on a redirect.

## Timing
- Reset values: `if_valid_o=0`, `imem_arvalid_o=0`, `imem_rready_o=0`, `pc_advance_o=0`, `if_inst_o=0`, `if_pc_o=0`, `if_fault_o=0`, `drop_q=0`.
- First request: IDLE runs in the first cycle after reset deasserts, and REQ in the next, with address 0x80000000.
- Latency with zero-wait memory (arready in the REQ cycle, rvalid on the first WAIT cycle):
  - IDLE at t, REQ at t+1, WAIT at t+2, HOLD at t+3.
  - Peak throughput is one instruction per 4 cycles.
- Memory stall: arbitrary arready/rvalid wait states are tolerated. There is no timeout.
- Simultaneous redirect and `imem_rvalid_i` in WAIT: the data is dropped.
- Simultaneous redirect and `id_ready_i` in HOLD: the redirect wins. There is no handshake and no advance.
- Reset mid-transaction returns to IDLE immediately. Any late memory response arriving afterwards is the memory model's responsibility; the bench resets memory alongside.

## Structure
- Shared package/define file holds:
  - the state encoding (2-bit localparams);
  - the reset PC 0x80000000 (already `RegBus`-width in the define file);
  - the fault instruction value `32'h0`;
  - the RRESP OKAY constant.
- Single module with no sub-module. The output buffer is plain registers inside the FSM.

## Test plan
- Reset release with memory returning 0x00000013_00100093 at 0x80000000:
  - HOLD at t+3 with `if_pc_o=0x80000000` and `if_inst_o=0x00100093`.
  - One `pc_advance_o` pulse when `id_ready_i=1`.
- PC 0x80000004, same data word -> `if_inst_o=0x00000013`, `imem_araddr_o=0x80000000`.
- Redirect asserted while in WAIT:
  - The response completes; `if_valid_o` never rises for that fetch.
  - The next request uses the target supplied on `pc_i`.
- `id_ready_i=0` for 5 cycles in HOLD -> outputs stable; `pc_advance_o=0` throughout; advance fires on the release cycle only.
- `imem_rresp_i=2'b10` -> `if_fault_o=1` and `if_inst_o=0`.
- `pc_i=0x80000002` -> no memory request; HOLD with `if_fault_o=1`.
